// File: rtl/cic_axis_bridge_pkg.sv
// Shared constants and the round/shift/saturate helper for the CIC-to-AXIS bridge.
// Defaults here seed the top-level parameters.
package cic_axis_bridge_pkg;

  localparam int INPUT_WIDTH_DEF = 32;
  localparam int TDATA_WIDTH_DEF = 16;
  localparam int SHIFT_DEF       = 8;
  localparam int DEPTH_DEF       = 8;
  localparam int FRAME_LEN_DEF   = 256;
  localparam int ADDR_W          = $clog2(DEPTH_DEF);
  localparam int OVF_CNT_W       = 16;

  // Round half toward +inf, arithmetic shift, clamp to a signed out_w-bit range.
  // Works in 64 bits, so it covers any INPUT_WIDTH up to 62.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                   input int shift,
                                                   input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r = value;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r     = r >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (r > max_v)      return max_v;
    else if (r < min_v) return min_v;
    else                return r;
  endfunction

endpackage

// File: rtl/cic_axis_bridge_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers.
// rdata reads 0 while empty so the bus is quiet when nothing is queued.
module cic_axis_bridge_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; emptiness is defined by the pointers alone,
  // which keeps the array a plain RAM and avoids a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // sees pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cic_axis_bridge.sv
// Rescales CIC decimator samples (round/shift/saturate) and streams them out over AXI4-Stream.
// Optional macro CIC_AXIS_BRIDGE_TLAST_EN adds m_axis_tlast with a per-frame marker.
module cic_axis_bridge
  import cic_axis_bridge_pkg::*;
#(
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int TDATA_WIDTH = TDATA_WIDTH_DEF,
  parameter int SHIFT       = SHIFT_DEF,
  parameter int DEPTH       = DEPTH_DEF
`ifdef CIC_AXIS_BRIDGE_TLAST_EN
  , parameter int FRAME_LEN = FRAME_LEN_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INPUT_WIDTH-1:0]   inF,
  input  logic                     d_clk,
  input  logic                     enable,
  input  logic                     clear_ovf,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     ovf_sticky,
  output logic [OVF_CNT_W-1:0]     ovf_count
`ifdef CIC_AXIS_BRIDGE_TLAST_EN
  , output logic                   m_axis_tlast
`endif
);

`ifdef CIC_AXIS_BRIDGE_TLAST_EN
  localparam int FIFO_W = TDATA_WIDTH + 1;
  localparam int FC_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`else
  localparam int FIFO_W = TDATA_WIDTH;
`endif

  logic                   d_clk_q;
  logic                   strobe;
  logic                   s1_valid;
  logic [TDATA_WIDTH-1:0] s1_data;
  logic signed [63:0]     in_ext;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic                   full;
  logic                   empty;
  logic [FIFO_W-1:0]      wdata;
  logic [FIFO_W-1:0]      rdata;

  assign strobe = d_clk & ~d_clk_q & enable;
  assign in_ext = 64'(signed'(inF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_clk_q  <= 1'b0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      d_clk_q  <= d_clk;
      s1_valid <= strobe;
      if (strobe) s1_data <= TDATA_WIDTH'(sat_round(in_ext, SHIFT, TDATA_WIDTH));
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign pop  = m_axis_tvalid & m_axis_tready;
  assign push = s1_valid & (~full | pop);
  assign drop = s1_valid & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clear_ovf) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
    end
  end

`ifdef CIC_AXIS_BRIDGE_TLAST_EN
  logic [FC_W-1:0] frame_cnt;
  logic            frame_end;

  assign frame_end = (frame_cnt == FC_W'(FRAME_LEN - 1));
  assign wdata     = {frame_end, s1_data};

  // Only accepted samples advance the frame position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       frame_cnt <= '0;
    else if (push) frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
  end

  assign m_axis_tlast = rdata[TDATA_WIDTH];
`else
  assign wdata = s1_data;
`endif

  cic_axis_bridge_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fill_level)
  );

  assign m_axis_tdata  = rdata[TDATA_WIDTH-1:0];
  assign m_axis_tvalid = ~empty;

endmodule

// File: doc/cic_axis_bridge.md
Name: cic_axis_bridge

Overview:
Sits directly downstream of the phasemeter CIC decimator and consumes its outF bus and d_clk decimation strobe, both synchronous to clk. Samples outF once per d_clk rising edge, then rescales it by rounding, arithmetic shift and saturation. Buffers the scaled samples in a small FIFO and presents them as an AXI4-Stream master to the downstream DMA/packetiser. Counts samples dropped on overflow.

Parameters:
INPUT_WIDTH, 32, width of CIC outF (signed two's complement)
TDATA_WIDTH, 16, width of m_axis_tdata (signed)
SHIFT, 8, right-shift applied before saturation (0..INPUT_WIDTH-1)
DEPTH, 8, FIFO entries (power of two, >=2)
FRAME_LEN, 256, samples per frame (used only when the optional feature is compiled in)

Ports:
clk  in  1  system clock (same clock as CIC)
rst  in  1  asynchronous, active-high reset
inF  in  INPUT_WIDTH  CIC output sample (outF)
d_clk  in  1  CIC decimation clock/strobe, synchronous to clk
enable  in  1  high = accept new samples; low = ignore strobes, FIFO keeps draining
clear_ovf  in  1  one-cycle pulse: clears ovf_sticky and ovf_count
m_axis_tdata  out  TDATA_WIDTH  scaled sample
m_axis_tvalid  out  1  FIFO non-empty
m_axis_tready  in  1  downstream ready
fill_level  out  clog2(DEPTH)+1  current FIFO occupancy
ovf_sticky  out  1  set on any dropped sample
ovf_count  out  16  dropped-sample count, saturates at 16'hFFFF

Behaviour:
- Reset: all outputs 0; FIFO empty; internal d_clk_q = 0; pipeline valid = 0. Reset asserted mid-operation flushes the FIFO immediately, and any in-flight sample is lost.
- Strobe: d_clk registered into d_clk_q. strobe = d_clk & ~d_clk_q & enable. inF is sampled on the same edge as the strobe.
- Stage 1 (registered): compute r = inF + (SHIFT>0 ? 2^(SHIFT-1) : 0) in INPUT_WIDTH+1 bits, then arithmetic shift right by SHIFT. Round half toward +inf. Saturate to [-2^(TDATA_WIDTH-1), 2^(TDATA_WIDTH-1)-1]. Set s1_valid = strobe.
- Stage 2: if s1_valid and the FIFO is not full, write the sample. Full with a simultaneous pop still accepts the write, and occupancy is unchanged.
- Overflow: if s1_valid and the FIFO is full with no pop in that cycle, drop the sample, set ovf_sticky, and increment ovf_count (saturating). If clear_ovf and a drop occur in the same cycle, the clear wins and the count ends at 0.
- Latency: m_axis_tvalid rises 2 clk edges after the edge that first samples d_clk high, when the FIFO was empty.
- AXIS: FIFO is first-word-fall-through. tdata equals the head entry whenever tvalid=1, and tdata/tvalid stay stable until a handshake (tvalid & tready). A pop on the last entry drops tvalid on the next cycle unless a write happens in that same cycle.
- Pointers: read/write pointers are clog2(DEPTH)+1 bits, wrap naturally. empty = pointers equal; full = MSBs differ and the remaining bits are equal. fill_level = wr_ptr - rd_ptr.
- d_clk held high produces a single strobe. A d_clk high pulse of one cycle is still detected.

Optional Feature:
CIC_AXIS_BRIDGE_TLAST_EN: adds output port m_axis_tlast (1 bit) and a frame counter.
- Counter increments on each FIFO write and wraps at FRAME_LEN.
- tlast is stored per entry, and is high on the sample with counter index FRAME_LEN-1.
- Dropped samples do not advance the counter.
- Reset and clear_ovf do not affect alignment except that reset zeroes the counter.
- Without the macro: no tlast port, no counter, no extra FIFO bit.

Decomposition:
- Package cic_axis_bridge_pkg: ADDR_W = clog2(DEPTH), OVF_CNT_W = 16, and the round/shift/saturate function sat_round(value, SHIFT, TDATA_WIDTH).
- Sub-module cic_axis_bridge_fifo: synchronous FWFT FIFO with async active-high reset, exposing push/pop/full/empty/level, width TDATA_WIDTH(+1 when TLAST_EN).

Test Plan:
- Rounding: inF=32'h00001280, one d_clk pulse -> tdata=16'h0013, tvalid 2 edges after d_clk sampled high. inF=32'hFFFFFF7F -> 16'hFFFF.
- Saturation: inF=32'h7FFFFFFF -> 16'h7FFF; inF=32'h80000000 -> 16'h8000.
- Overflow: tready=0, 10 strobes, DEPTH=8 -> fill_level=8, ovf_count=2, ovf_sticky=1. Then tready=1 -> 8 samples out in order; clear_ovf -> count 0.
- Backpressure: tready toggles every other cycle with a strobe every 16 clk (CIC R=16) -> no drops, every tdata held stable while tvalid & !tready.
- Reset mid-stream: assert rst with 5 entries queued -> tvalid=0, fill_level=0 immediately. After release, the next strobe yields a fresh sample with no stale data.
- TLAST_EN, FRAME_LEN=4: 12 strobes with tready=1 -> tlast high on samples 4, 8, 12 only.
